// File: rtl/four_bit_adder_pkg.sv
// rtl/four_bit_adder_pkg.sv - shared constants for the registered ripple-carry adder
//
// Purpose : Holds the default operand width used by the adder, its bus
//           interface and any datapath that instantiates them.
// Contents: ADDER_WIDTH - default operand/sum width in bits.
package four_bit_adder_pkg;

  localparam int ADDER_WIDTH = 4;

endpackage

// File: rtl/four_bit_adder_if.sv
// rtl/four_bit_adder_if.sv - operand/result bundle for the registered adder
//
// Purpose : Groups the adder operands and registered results so a datapath
//           can hand the whole adder port set around as one object.
// Signals : a, b  operands (unsigned, WIDTH bits)
//           co    carry-in to bit 0 (historic name kept for existing users)
//           s     registered sum bits [WIDTH-1:0]
//           c4    registered carry-out of the MSB
// Modports: master drives operands and reads results; slave is the adder.
interface four_bit_adder_if
  import four_bit_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             co;
  logic [WIDTH-1:0] s;
  logic             c4;

  modport master (
    output a,
    output b,
    output co,
    input  s,
    input  c4
  );

  modport slave (
    input  a,
    input  b,
    input  co,
    output s,
    output c4
  );

endinterface

// File: rtl/four_bit_adder_full_adder.sv
// rtl/four_bit_adder_full_adder.sv - single-bit full adder cell of the ripple chain
//
// Purpose : One stage of the ripple-carry chain.
// Ports   : a, b  operand bits
//           cin   carry from the previous stage
//           sum   a ^ b ^ cin
//           cout  carry into the next stage
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign sum      = half_sum ^ cin;
  // Generate when both bits set, propagate the incoming carry when exactly one is.
  assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/four_bit_adder.sv
// rtl/four_bit_adder.sv - registered WIDTH-bit ripple-carry adder
//
// Purpose : {c4, s} <= a + b + co on every rising clk edge, one cycle latency,
//           one result per cycle. Results are undefined until the first reset.
// Ports   : clk  clock, all state changes on the rising edge
//           rst  synchronous active-high reset; clears s and c4 and ignores
//                the operands present on that edge
//           bus  operand/result bundle (slave side): a, b, co in; s, c4 out
module four_bit_adder
  import four_bit_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input logic             clk,
  input logic             rst,
  four_bit_adder_if.slave bus
);

  // carry[0] is the external carry-in; carry[WIDTH] is the carry-out of the MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = bus.co;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a    (bus.a[i]),
      .b    (bus.b[i]),
      .cin  (carry[i]),
      .sum  (sum_comb[i]),
      .cout (carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.s  <= '0;
      bus.c4 <= 1'b0;
    end else begin
      bus.s  <= sum_comb;
      bus.c4 <= carry[WIDTH];
    end
  end

endmodule

// File: tb/tb_four_bit_adder.sv
// tb/tb_four_bit_adder.sv - self-checking bench for the registered adder
module tb_four_bit_adder;
  import four_bit_adder_pkg::*;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  four_bit_adder_if #(.WIDTH(4)) bus ();

  four_bit_adder #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       r;
    logic [3:0] a;
    logic [3:0] b;
    logic       co;
    logic [3:0] exp_s;
    logic       exp_c4;
  } vec_t;

  vec_t vecs [14];

  // Reference: plain arithmetic on a 5-bit result, zero while in reset.
  function automatic logic [4:0] ref_sum(input logic r, input logic [3:0] a,
                                         input logic [3:0] b, input logic co);
    int total;
    total = int'(a) + int'(b) + int'(co);
    return r ? 5'd0 : total[4:0];
  endfunction

  task automatic check(input string name, input logic [3:0] exp_s, input logic exp_c4);
    tests_run++;
    if (bus.s !== exp_s || bus.c4 !== exp_c4) begin
      tests_failed++;
      $display("FAIL %s: got s=%b c4=%b, expected s=%b c4=%b",
               name, bus.s, bus.c4, exp_s, exp_c4);
    end
  endtask

  // Drive operands away from the edge, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                      input logic co);
    rst    = r;
    bus.a  = a;
    bus.b  = b;
    bus.co = co;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] exp;
    logic [8:0] v;
    logic       r;
    logic [3:0] ra, rb;
    logic       rc;

    tests_run    = 0;
    tests_failed = 0;
    rst    = 1'b1;
    bus.a  = '0;
    bus.b  = '0;
    bus.co = 1'b0;

    vecs[0]  = '{"reset_cycle1",    1'b1, 4'b0011, 4'b0001, 1'b1, 4'b0000, 1'b0};
    vecs[1]  = '{"reset_cycle2",    1'b1, 4'b0011, 4'b0001, 1'b1, 4'b0000, 1'b0};
    vecs[2]  = '{"3+1+1",           1'b0, 4'b0011, 4'b0001, 1'b1, 4'b0101, 1'b0};
    vecs[3]  = '{"2+1+1",           1'b0, 4'b0010, 4'b0001, 1'b1, 4'b0100, 1'b0};
    vecs[4]  = '{"0+1+0",           1'b0, 4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b0};
    vecs[5]  = '{"f+1+0_wrap",      1'b0, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1};
    vecs[6]  = '{"f+f+1_max",       1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};
    vecs[7]  = '{"0+0+0_min",       1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[8]  = '{"f+0+1_wrap",      1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1};
    vecs[9]  = '{"a+5+0",           1'b0, 4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0};
    vecs[10] = '{"midstream_reset", 1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0};
    vecs[11] = '{"after_reset",     1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};
    vecs[12] = '{"8+8+0",           1'b0, 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1};
    vecs[13] = '{"7+8+1",           1'b0, 4'b0111, 4'b1000, 1'b1, 4'b0000, 1'b1};

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].co);
      check(vecs[i].name, vecs[i].exp_s, vecs[i].exp_c4);
    end

    // Outputs must hold while operands change between edges.
    bus.a  = 4'b0001;
    bus.b  = 4'b0010;
    bus.co = 1'b0;
    #3;
    check("hold_between_edges", 4'b0000, 1'b1);
    @(posedge clk);
    #1;
    check("after_hold_edge", 4'b0011, 1'b0);

    // Randomised back-to-back stream with occasional resets.
    for (int i = 0; i < 200; i++) begin
      r  = ($urandom_range(0, 9) == 0);
      ra = 4'($urandom);
      rb = 4'($urandom);
      rc = 1'($urandom);
      step(r, ra, rb, rc);
      exp = ref_sum(r, ra, rb, rc);
      check("random", exp[3:0], exp[4]);
    end

    // Exhaustive sweep of every operand/carry-in combination.
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      step(1'b0, v[3:0], v[7:4], v[8]);
      exp = ref_sum(1'b0, v[3:0], v[7:4], v[8]);
      check("sweep", exp[3:0], exp[4]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
